secded_stream_codec: RTL and testbench
======================================

# secded_stream_codec

Parametrised, pipelined SECDED (extended Hamming) codec serving as the hardware successor to the program-1 parity-insertion routine. It accepts a stream of words over a valid/ready handshake. Each word is either encoded (data to codeword with parity inserted) or decoded (codeword to corrected data plus error status), selected per word. It sits between data memory and the processor datapath as a memory-mapped accelerator, with optional saturating error counters.

## Interface
- `R`, 4: number of Hamming parity bits, legal range 3..6.
  - Derived: K = 2^R − R − 1 data bits; N = 2^R codeword bits. Default gives K=11, N=16.
- `CNT_W`, 16: width of each error counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input word present.
- `in_ready` out 1: codec can accept this cycle.
- `in_mode` in 1: 0 = encode, 1 = decode; sampled with the word.
- `in_data` in N: word to process. Encode uses `in_data[K-1:0]`; upper bits are ignored.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out N: result. Encode gives the codeword; decode gives `{(N−K)'b0, data}`.
- `out_status` out 2: 00 clean, 01 single error corrected, 10 double error detected. Always 00 for encode.
- `cnt_clr` in 1: synchronous clear of both counters.
- `cnt_single` out CNT_W: count of decode results with status 01.
- `cnt_double` out CNT_W: count of decode results with status 10.

## Operation
Codeword layout is by bit index j, 0..N−1:
- j = 0: overall parity p0.
- j a power of two: parity p_j = XOR of all bits at positions ≥1 whose index has that bit set.
- All other positions hold data bits in ascending order. Data bit 0 goes to position 3.
- p0 = XOR of bits 1..N−1, so the whole codeword has even parity.
- Example, R=4: `{d[10:4], p8, d[3:1], p4, d[0], p2, p1, p0}`.

Decode:
- Syndrome s = XOR of the indices j≥1 of all set bits.
- q = XOR of all N bits.
- s=0, q=0: status 00; data extracted unchanged.
- q=1: single error at position s; flip that bit, then extract. s=0 means p0 itself was flipped and the data is unchanged. Status 01.
- s≠0, q=0: double error. Data is extracted uncorrected; status 10.
- s ≥ N cannot occur, because s is R bits wide.

Pipeline: two register stages, S1 and S2, each with its own valid flag.
- S1 captures in_data and in_mode, then computes parity/syndrome combinationally.
- S2 holds the final out_data and out_status. Outputs are driven directly from the S2 registers.
- S2 advances when `!out_valid || out_ready`.
- S1 advances when S2 advances or S1 is empty.
- `in_ready = !s1_valid || s2_advance`. This is a combinational path from out_ready.
- A word is accepted on `in_valid && in_ready`.
- out_data and out_status are held stable while `out_valid && !out_ready`.

Counters (when compiled in):
- Increment on an output handshake whose status is 01 or 10, respectively.
- Saturate at 2^CNT_W − 1.
- `cnt_clr` forces both counters to 0 on the next edge. If clear coincides with an increment, clear wins.

Reset:
- Asynchronously clears both valid flags, all data/status registers, and both counters.
- In-flight words are discarded.
- Output values during reset: out_valid=0, out_data=0, out_status=00, in_ready=1, counters=0.

## Timing
- Latency is 2 cycles: a word accepted at edge t gives out_valid high after edge t+1 (visible in the cycle following it) with no stall.
- Throughput is 1 word per cycle with out_ready held high.
- Under stall, the pipeline holds 2 words. in_ready drops only when both stages are full and out_ready=0.
- When out_ready rises, the consumer takes a word and a new word is accepted on the same edge, with no bubble.
- Reset deassertion: in_ready=1 in the first cycle after.

## Configuration
- `SECDED_ERRCNT_EN` defined: counters are present as specified.
- Not defined: no counter registers are built; cnt_single and cnt_double are tied to 0; cnt_clr is ignored.

## Test plan
All scenarios use R=4.
- Encode: in_data=16'h0401 → out_data=16'h8118, status 00, 2 cycles after acceptance. Encode 16'h0000 → 16'h0000.
- Decode 16'h8118 → 16'h0401, 00. Decode 16'h8138 (bit 5 flipped) → 16'h0401, 01, cnt_single=1. Decode 16'h8119 (p0 flipped) → 16'h0401, 01.
- Decode 16'h8338 (bits 5 and 9 flipped) → out_data 16'h0413, status 10, cnt_double=1.
- Back-to-back stream of 20 mixed encode/decode words with random out_ready:
  - Results are in order, none lost or duplicated.
  - in_ready is 0 only when 2 words are held.
  - out_data is stable while stalled.
- Counter edges with CNT_W=2: 5 single-error decodes → cnt_single=3. cnt_clr asserted on the same cycle as an error handshake → counters 0.
- Assert reset asynchronously with 2 words in flight → out_valid=0 immediately, counters 0, no stale output after release. Repeat the counter scenarios without SECDED_ERRCNT_EN → counters stay 0.

Source files
------------

// File: rtl/secded_stream_codec_if.sv
// Stream bundle for secded_stream_codec: the input word channel and the result channel.
interface secded_stream_codec_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   out_status;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_status
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_status
    );
endinterface

// File: rtl/secded_stream_codec.sv
// Two-stage pipelined SECDED (extended Hamming) encoder/decoder on a valid/ready stream.
// Define SECDED_ERRCNT_EN to build the saturating single/double error counters.
module secded_stream_codec #(
    parameter int R     = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    secded_stream_codec_if.slave bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     cnt_single,
    output logic [CNT_W-1:0]     cnt_double
);
    localparam int N = 2 ** R;
    localparam int K = N - R - 1;

    function automatic logic is_pow2(input int j);
        return (j & (j - 1)) == 0;
    endfunction

    function automatic logic [N-1:0] encode(input logic [K-1:0] d);
        logic [N-1:0] cw;
        int           di;
        cw = '0;
        di = 0;
        for (int j = 1; j < N; j++) begin
            if (!is_pow2(j)) begin
                cw[j] = d[di];
                di++;
            end
        end
        for (int r = 0; r < R; r++) begin
            for (int j = 1; j < N; j++) begin
                if (j[r] && !is_pow2(j)) cw[1 << r] = cw[1 << r] ^ cw[j];
            end
        end
        cw[0] = ^cw[N-1:1];
        return cw;
    endfunction

    function automatic logic [K-1:0] extract(input logic [N-1:0] cw);
        logic [K-1:0] d;
        int           di;
        d  = '0;
        di = 0;
        for (int j = 1; j < N; j++) begin
            if (!is_pow2(j)) begin
                d[di] = cw[j];
                di++;
            end
        end
        return d;
    endfunction

    logic         s1_valid_q, s1_valid_d;
    logic         s1_mode_q, s1_mode_d;
    logic [N-1:0] s1_data_q, s1_data_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_data_q, out_data_d;
    logic [1:0]   out_status_q, out_status_d;

    logic         s2_advance;
    logic [R-1:0] syndrome;
    logic         parity;
    logic [N-1:0] corrected;
    logic [N-1:0] result_data;
    logic [1:0]   result_status;

    // Syndrome is the XOR of set-bit indices; odd overall parity means one flipped bit.
    always_comb begin
        syndrome = '0;
        for (int j = 1; j < N; j++) begin
            if (s1_data_q[j]) syndrome = syndrome ^ j[R-1:0];
        end
        parity    = ^s1_data_q;
        corrected = s1_data_q;
        if (parity) corrected[syndrome] = ~s1_data_q[syndrome];
        result_data   = '0;
        result_status = 2'b00;
        if (s1_mode_q) begin
            result_data[K-1:0] = extract(corrected);
            if (parity)                 result_status = 2'b01;
            else if (syndrome != '0)    result_status = 2'b10;
        end else begin
            result_data = encode(s1_data_q[K-1:0]);
        end
    end

    assign s2_advance   = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid_q || s2_advance;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_mode_d    = s1_mode_q;
        s1_data_d    = s1_data_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_status_d = out_status_q;
        if (bus.in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_mode_d = bus.in_mode;
                s1_data_d = bus.in_data;
            end
        end
        if (s2_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d   = result_data;
                out_status_d = result_status;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_data_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_status_q <= 2'b00;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_mode_q    <= s1_mode_d;
            s1_data_q    <= s1_data_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_status_q <= out_status_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_status = out_status_q;

`ifdef SECDED_ERRCNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
    logic [CNT_W-1:0] cnt_double_q, cnt_double_d;
    logic             out_fire;

    // Clear takes priority over a coincident increment.
    always_comb begin
        out_fire     = out_valid_q && bus.out_ready;
        cnt_single_d = cnt_single_q;
        cnt_double_d = cnt_double_q;
        if (cnt_clr) begin
            cnt_single_d = '0;
            cnt_double_d = '0;
        end else if (out_fire) begin
            if (out_status_q == 2'b01 && cnt_single_q != '1) cnt_single_d = cnt_single_q + CNT_ONE;
            if (out_status_q == 2'b10 && cnt_double_q != '1) cnt_double_d = cnt_double_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else begin
            cnt_single_q <= cnt_single_d;
            cnt_double_q <= cnt_double_d;
        end
    end

    assign cnt_single = cnt_single_q;
    assign cnt_double = cnt_double_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign cnt_single     = '0;
    assign cnt_double     = '0;
`endif
endmodule

// File: tb/tb_secded_stream_codec.sv
// Directed, table-driven bench for secded_stream_codec (R=4, CNT_W=2) with stream and reset corner cases.
module tb_secded_stream_codec;
`ifdef SECDED_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int CNT_MAX = 3;
    localparam int NVEC    = 11;

    typedef struct {
        logic        mode;
        logic [15:0] din;
        logic [15:0] dout;
        logic [1:0]  st;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cnt_clr;
    logic [1:0] cnt_single;
    logic [1:0] cnt_double;

    int errors = 0;
    int checks = 0;
    int exp_single = 0;
    int exp_double = 0;
    vec_t vecs[NVEC];

    secded_stream_codec_if #(.N(16)) bus ();

    secded_stream_codec #(.R(4), .CNT_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
        .cnt_single(cnt_single),
        .cnt_double(cnt_double)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string name);
        check_output({name, " cnt_single"}, 32'(cnt_single), 32'(exp_single));
        check_output({name, " cnt_double"}, 32'(cnt_double), 32'(exp_double));
    endtask

    // One word through an idle pipeline with out_ready high: latency, result and counter update.
    task automatic apply_stimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        bus.in_valid  = 1'b1;
        bus.in_mode   = v.mode;
        bus.in_data   = v.din;
        bus.out_ready = 1'b1;
        #1;
        check_output($sformatf("vec%0d in_ready", idx), 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        check_output($sformatf("vec%0d early out_valid", idx), 32'(bus.out_valid), 32'd0);
        step();
        check_output($sformatf("vec%0d out_valid", idx), 32'(bus.out_valid), 32'd1);
        check_output($sformatf("vec%0d out_data", idx), 32'(bus.out_data), 32'(v.dout));
        check_output($sformatf("vec%0d out_status", idx), 32'(bus.out_status), 32'(v.st));
        if (CNT_EN && v.st == 2'b01 && exp_single < CNT_MAX) exp_single++;
        if (CNT_EN && v.st == 2'b10 && exp_double < CNT_MAX) exp_double++;
        step();
        check_output($sformatf("vec%0d drained", idx), 32'(bus.out_valid), 32'd0);
        check_counters($sformatf("vec%0d", idx));
    endtask

    // Mixed stream with random back-pressure: ordering, occupancy-based in_ready, stall stability.
    task automatic run_stream();
        logic [15:0] exp_data[$];
        logic [1:0]  exp_st[$];
        logic [15:0] last_data;
        logic [1:0]  last_st;
        logic        last_stall;
        int          sent, recv, occ, cyc;
        vec_t        v;
        sent = 0; recv = 0; occ = 0; cyc = 0;
        last_stall = 1'b0;
        last_data  = '0;
        last_st    = '0;
        while (recv < 20 && cyc < 2000) begin
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (sent < 20 && $urandom_range(0, 3) != 0) begin
                v = vecs[sent % NVEC];
                bus.in_valid = 1'b1;
                bus.in_mode  = v.mode;
                bus.in_data  = v.din;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            check_output("stream in_ready", 32'(bus.in_ready), 32'(!(occ == 2 && !bus.out_ready)));
            if (last_stall) begin
                check_output("stream stall data", 32'(bus.out_data), 32'(last_data));
                check_output("stream stall status", 32'(bus.out_status), 32'(last_st));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL stream extra: got %h required no output", bus.out_data);
                end else begin
                    check_output("stream data", 32'(bus.out_data), 32'(exp_data.pop_front()));
                    check_output("stream status", 32'(bus.out_status), 32'(exp_st.pop_front()));
                end
                recv++;
                occ--;
            end
            if (bus.in_valid && bus.in_ready) begin
                v = vecs[sent % NVEC];
                exp_data.push_back(v.dout);
                exp_st.push_back(v.st);
                sent++;
                occ++;
            end
            last_stall = bus.out_valid && !bus.out_ready;
            last_data  = bus.out_data;
            last_st    = bus.out_status;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check_output("stream received", 32'(recv), 32'd20);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 16'h0401, 16'h8118, 2'b00};
        vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 2'b00};
        vecs[2]  = '{1'b0, 16'h07FF, 16'hFFFF, 2'b00};
        vecs[3]  = '{1'b0, 16'hF801, 16'h000F, 2'b00};
        vecs[4]  = '{1'b1, 16'h8118, 16'h0401, 2'b00};
        vecs[5]  = '{1'b1, 16'h8138, 16'h0401, 2'b01};
        vecs[6]  = '{1'b1, 16'h8119, 16'h0401, 2'b01};
        vecs[7]  = '{1'b1, 16'h8338, 16'h0413, 2'b10};
        vecs[8]  = '{1'b1, 16'h7FFF, 16'h07FF, 2'b01};
        vecs[9]  = '{1'b1, 16'hFFF9, 16'h07FF, 2'b10};
        vecs[10] = '{1'b1, 16'h0000, 16'h0000, 2'b00};

        reset         = 1'b1;
        cnt_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        #2;
        check_output("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_output("reset in_ready", 32'(bus.in_ready), 32'd1);
        check_output("reset out_data", 32'(bus.out_data), 32'd0);
        check_output("reset out_status", 32'(bus.out_status), 32'd0);
        check_counters("reset");
        step();
        step();
        reset = 1'b0;
        #1;
        check_output("post-reset in_ready", 32'(bus.in_ready), 32'd1);
        check_output("post-reset out_valid", 32'(bus.out_valid), 32'd0);
        step();

        for (int i = 0; i < NVEC; i++) apply_stimulus(i);

        run_stream();

        cnt_clr       = 1'b1;
        bus.out_ready = 1'b1;
        step();
        cnt_clr    = 1'b0;
        exp_single = 0;
        exp_double = 0;
        check_counters("clear");

        for (int i = 0; i < 5; i++) apply_stimulus(5);
        check_output("saturated cnt_single", 32'(cnt_single), CNT_EN ? 32'd3 : 32'd0);
        apply_stimulus(7);

        // Park a single-error result at the output, then clear on the same edge it is taken.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = vecs[5].mode;
        bus.in_data   = vecs[5].din;
        step();
        bus.in_valid = 1'b0;
        step();
        check_output("clr-race held valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        cnt_clr       = 1'b1;
        step();
        cnt_clr    = 1'b0;
        exp_single = 0;
        exp_double = 0;
        check_output("clr-race drained", 32'(bus.out_valid), 32'd0);
        check_counters("clr-race");

        apply_stimulus(7);

        // Two words in flight, then an asynchronous reset mid-cycle.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = vecs[0].mode;
        bus.in_data   = vecs[0].din;
        step();
        bus.in_mode = vecs[2].mode;
        bus.in_data = vecs[2].din;
        step();
        bus.in_valid = 1'b0;
        check_output("full in_ready", 32'(bus.in_ready), 32'd0);
        check_output("full out_valid", 32'(bus.out_valid), 32'd1);
        check_output("full out_data", 32'(bus.out_data), 32'h8118);
        #2;
        reset = 1'b1;
        #1;
        exp_single = 0;
        exp_double = 0;
        check_output("async reset out_valid", 32'(bus.out_valid), 32'd0);
        check_output("async reset out_data", 32'(bus.out_data), 32'd0);
        check_output("async reset in_ready", 32'(bus.in_ready), 32'd1);
        check_counters("async reset");
        step();
        #2;
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("no stale out_valid", 32'(bus.out_valid), 32'd0);
            check_output("no stale in_ready", 32'(bus.in_ready), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
